// File: rtl/tl_rx_fc_update_scheduler.sv
// RX flow-control credit counters plus InitFC/UpdateFC scheduling onto one shared DLL request port.
// Optional macro TL_RX_FC_PERIODIC_UPDATE_EN adds a periodic refresh of all three classes.
module tl_rx_fc_update_scheduler #(
    parameter int FC_HDR_CREDS_WIDTH   = 12,
    parameter int FC_DATA_CREDS_WIDTH  = 16,
    parameter int DLL_HDR_CREDS_WIDTH  = 8,
    parameter int DLL_DATA_CREDS_WIDTH = 12,
    parameter int HDR_INIT             = 32,
    parameter int DATA_INIT            = 512,
    parameter int UPD_PERIOD           = 1023
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rel_valid,
    input  logic [1:0]                      rel_typ,
    input  logic [3:0]                      rel_hdr_creds,
    input  logic [8:0]                      rel_data_creds,
    input  logic [1:0]                      cfg_hdr_scale,
    input  logic [1:0]                      cfg_data_scale,
    output logic                            upd_valid,
    input  logic                            upd_ready,
    output logic                            upd_init,
    output logic [1:0]                      upd_typ,
    output logic [DLL_HDR_CREDS_WIDTH-1:0]  upd_hdr_creds,
    output logic [DLL_DATA_CREDS_WIDTH-1:0] upd_data_creds,
    output logic [1:0]                      upd_hdr_scale,
    output logic [1:0]                      upd_data_scale,
    output logic [FC_HDR_CREDS_WIDTH-1:0]   p_hdr_creds_reg,
    output logic [FC_HDR_CREDS_WIDTH-1:0]   np_hdr_creds_reg,
    output logic [FC_HDR_CREDS_WIDTH-1:0]   cpl_hdr_creds_reg,
    output logic [FC_DATA_CREDS_WIDTH-1:0]  p_data_creds_reg,
    output logic [FC_DATA_CREDS_WIDTH-1:0]  np_data_creds_reg,
    output logic [FC_DATA_CREDS_WIDTH-1:0]  cpl_data_creds_reg,
    output logic                            init_done
);

    typedef enum logic [1:0] {INIT_P, INIT_NP, INIT_CPL, ACTIVE} state_t;

    localparam logic [FC_HDR_CREDS_WIDTH-1:0]  HDR_RST  = FC_HDR_CREDS_WIDTH'(HDR_INIT);
    localparam logic [FC_DATA_CREDS_WIDTH-1:0] DATA_RST = FC_DATA_CREDS_WIDTH'(DATA_INIT);

    state_t                         state;
    logic [FC_HDR_CREDS_WIDTH-1:0]  hdr_cnt  [3];
    logic [FC_DATA_CREDS_WIDTH-1:0] data_cnt [3];
    logic [2:0]                     pend;
    logic [1:0]                     rr;
    logic [2:0]                     rel_hit;
    logic [2:0]                     tick_set;
    logic [2:0]                     grant_mask;
    logic                           grant;
    logic [1:0]                     grant_cls;
    logic                           issue;
    logic [1:0]                     issue_cls;

    function automatic int unsigned scale_shift(input logic [1:0] s);
        case (s)
            2'b10:   return 2;
            2'b11:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [DLL_HDR_CREDS_WIDTH-1:0] scale_hdr(
        input logic [FC_HDR_CREDS_WIDTH-1:0] c, input logic [1:0] s);
        logic [FC_HDR_CREDS_WIDTH-1:0] v;
        v = c >> scale_shift(s);
        return v[DLL_HDR_CREDS_WIDTH-1:0];
    endfunction

    function automatic logic [DLL_DATA_CREDS_WIDTH-1:0] scale_data(
        input logic [FC_DATA_CREDS_WIDTH-1:0] c, input logic [1:0] s);
        logic [FC_DATA_CREDS_WIDTH-1:0] v;
        v = c >> scale_shift(s);
        return v[DLL_DATA_CREDS_WIDTH-1:0];
    endfunction

    function automatic logic [1:0] next_cls(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    always_comb begin
        rel_hit = 3'b000;
        if (rel_valid && rel_typ != 2'b11)
            rel_hit[rel_typ] = 1'b1;
    end

    // Round-robin search starting at rr; only when the port is idle in ACTIVE.
    always_comb begin
        logic [1:0] c1;
        logic [1:0] c2;
        c1        = next_cls(rr);
        c2        = next_cls(c1);
        grant     = (state == ACTIVE) && !upd_valid && (pend != 3'b000);
        if (pend[rr])      grant_cls = rr;
        else if (pend[c1]) grant_cls = c1;
        else               grant_cls = c2;
        grant_mask = 3'b000;
        if (grant)
            grant_mask[grant_cls] = 1'b1;
        if (state == ACTIVE) begin
            issue     = grant;
            issue_cls = grant_cls;
        end else begin
            issue     = !upd_valid;
            issue_cls = state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= INIT_P;
            rr             <= 2'd0;
            pend           <= 3'b000;
            upd_valid      <= 1'b0;
            upd_init       <= 1'b0;
            upd_typ        <= 2'd0;
            upd_hdr_creds  <= '0;
            upd_data_creds <= '0;
            init_done      <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                hdr_cnt[c]  <= HDR_RST;
                data_cnt[c] <= DATA_RST;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (rel_hit[c]) begin
                    hdr_cnt[c]  <= hdr_cnt[c] + FC_HDR_CREDS_WIDTH'(rel_hdr_creds);
                    data_cnt[c] <= data_cnt[c] + FC_DATA_CREDS_WIDTH'(rel_data_creds);
                end
            end
            // A release in the grant cycle re-arms the flag the grant is clearing.
            pend <= (pend & ~grant_mask) | rel_hit | tick_set;

            if (upd_valid && upd_ready) begin
                upd_valid <= 1'b0;
                case (state)
                    INIT_P:   state <= INIT_NP;
                    INIT_NP:  state <= INIT_CPL;
                    INIT_CPL: begin
                        state     <= ACTIVE;
                        init_done <= 1'b1;
                    end
                    default:  state <= ACTIVE;
                endcase
            end else if (issue) begin
                upd_valid      <= 1'b1;
                upd_init       <= (state != ACTIVE);
                upd_typ        <= issue_cls;
                upd_hdr_creds  <= scale_hdr(hdr_cnt[issue_cls], cfg_hdr_scale);
                upd_data_creds <= scale_data(data_cnt[issue_cls], cfg_data_scale);
                if (state == ACTIVE)
                    rr <= next_cls(issue_cls);
            end
        end
    end

`ifdef TL_RX_FC_PERIODIC_UPDATE_EN
    localparam int TMR_W = $clog2(UPD_PERIOD + 1);
    logic [TMR_W-1:0] tmr;
    logic             tmr_hit;

    assign tmr_hit = (state == ACTIVE) && (tmr == TMR_W'(UPD_PERIOD - 1));

    // Held at zero outside ACTIVE, so it restarts when init_done rises.
    always_ff @(posedge clk) begin
        if (rst || state != ACTIVE || tmr_hit)
            tmr <= '0;
        else
            tmr <= tmr + TMR_W'(1);
    end

    assign tick_set = tmr_hit ? 3'b111 : 3'b000;
`else
    // Period only matters when the refresh timer is built in.
    assign tick_set = (UPD_PERIOD < 0) ? 3'b111 : 3'b000;
`endif

    assign upd_hdr_scale      = cfg_hdr_scale;
    assign upd_data_scale     = cfg_data_scale;
    assign p_hdr_creds_reg    = hdr_cnt[0];
    assign np_hdr_creds_reg   = hdr_cnt[1];
    assign cpl_hdr_creds_reg  = hdr_cnt[2];
    assign p_data_creds_reg   = data_cnt[0];
    assign np_data_creds_reg  = data_cnt[1];
    assign cpl_data_creds_reg = data_cnt[2];

endmodule

// File: tb/tb_tl_rx_fc_update_scheduler.sv
// Bench for tl_rx_fc_update_scheduler: vector table, directed corner sequences, randomized traffic vs. a credit model.
module tb_tl_rx_fc_update_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rel_valid = 1'b0;
    logic [1:0]  rel_typ = 2'd0;
    logic [3:0]  rel_hdr_creds = 4'd0;
    logic [8:0]  rel_data_creds = 9'd0;
    logic [1:0]  cfg_hdr_scale = 2'd0;
    logic [1:0]  cfg_data_scale = 2'd0;
    logic        upd_ready = 1'b1;
    logic        upd_valid, upd_init, init_done;
    logic [1:0]  upd_typ, upd_hdr_scale, upd_data_scale;
    logic [7:0]  upd_hdr_creds;
    logic [11:0] upd_data_creds;
    logic [11:0] p_hdr_creds_reg, np_hdr_creds_reg, cpl_hdr_creds_reg;
    logic [15:0] p_data_creds_reg, np_data_creds_reg, cpl_data_creds_reg;

    tl_rx_fc_update_scheduler dut (
        .clk(clk), .rst(rst),
        .rel_valid(rel_valid), .rel_typ(rel_typ),
        .rel_hdr_creds(rel_hdr_creds), .rel_data_creds(rel_data_creds),
        .cfg_hdr_scale(cfg_hdr_scale), .cfg_data_scale(cfg_data_scale),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_init(upd_init),
        .upd_typ(upd_typ), .upd_hdr_creds(upd_hdr_creds), .upd_data_creds(upd_data_creds),
        .upd_hdr_scale(upd_hdr_scale), .upd_data_scale(upd_data_scale),
        .p_hdr_creds_reg(p_hdr_creds_reg), .np_hdr_creds_reg(np_hdr_creds_reg),
        .cpl_hdr_creds_reg(cpl_hdr_creds_reg), .p_data_creds_reg(p_data_creds_reg),
        .np_data_creds_reg(np_data_creds_reg), .cpl_data_creds_reg(cpl_data_creds_reg),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       init;
        logic [1:0] typ;
        logic [7:0] h;
        logic [11:0] d;
        logic [1:0] hs;
        logic [1:0] ds;
    } txn_t;

    typedef struct {
        logic [1:0] typ;
        logic [3:0] h;
        logic [8:0] d;
        int         cls;
        int         eh;
        int         ed;
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          last_xfer = -1;
    bit          model_ok = 1'b0;
    bit          prev_hold = 1'b0;
    logic [7:0]  prev_h;
    logic [11:0] prev_d;
    logic [1:0]  prev_t;
    logic [11:0] m_hdr [3];
    logic [15:0] m_data [3];
    txn_t        txq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: counters follow releases one cycle later, requests observed at the port.
    always @(negedge clk) begin
        cyc++;
        if (model_ok) begin
            chk("p_hdr", {20'd0, p_hdr_creds_reg}, {20'd0, m_hdr[0]});
            chk("np_hdr", {20'd0, np_hdr_creds_reg}, {20'd0, m_hdr[1]});
            chk("cpl_hdr", {20'd0, cpl_hdr_creds_reg}, {20'd0, m_hdr[2]});
            chk("p_data", {16'd0, p_data_creds_reg}, {16'd0, m_data[0]});
            chk("np_data", {16'd0, np_data_creds_reg}, {16'd0, m_data[1]});
            chk("cpl_data", {16'd0, cpl_data_creds_reg}, {16'd0, m_data[2]});
            if (prev_hold) begin
                chk("hold_valid", {31'd0, upd_valid}, 32'd1);
                chk("hold_typ", {30'd0, upd_typ}, {30'd0, prev_t});
                chk("hold_hdr", {24'd0, upd_hdr_creds}, {24'd0, prev_h});
                chk("hold_data", {20'd0, upd_data_creds}, {20'd0, prev_d});
            end
            if (upd_valid && upd_ready && !rst) begin
                if (last_xfer >= 0)
                    chk("xfer_gap", {31'd0, (cyc - last_xfer) >= 2}, 32'd1);
                chk("init_flag", {31'd0, upd_init}, {31'd0, !init_done});
                txq.push_back('{upd_init, upd_typ, upd_hdr_creds, upd_data_creds,
                                upd_hdr_scale, upd_data_scale});
                last_xfer = cyc;
            end
        end
        prev_hold = model_ok && !rst && upd_valid && !upd_ready;
        prev_h = upd_hdr_creds;
        prev_d = upd_data_creds;
        prev_t = upd_typ;
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                m_hdr[c]  = 12'd32;
                m_data[c] = 16'd512;
            end
            model_ok  = 1'b1;
            last_xfer = -1;
        end else if (model_ok && rel_valid && rel_typ != 2'b11) begin
            m_hdr[rel_typ]  = m_hdr[rel_typ] + 12'(rel_hdr_creds);
            m_data[rel_typ] = m_data[rel_typ] + 16'(rel_data_creds);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rel(input logic [1:0] t, input logic [3:0] h, input logic [8:0] d);
        rel_valid = 1'b1;
        rel_typ = t;
        rel_hdr_creds = h;
        rel_data_creds = d;
        step();
        rel_valid = 1'b0;
    endtask

    task automatic drain();
        upd_ready = 1'b1;
        rel_valid = 1'b0;
        repeat (12) step();
    endtask

    task automatic wait_txn(input int n, input int budget, input string name);
        for (int i = 0; i < budget && txq.size() < n; i++) step();
        chk(name, txq.size(), n);
    endtask

    function automatic int last_of(input logic [1:0] c);
        int idx = -1;
        for (int i = 0; i < txq.size(); i++)
            if (txq[i].typ == c) idx = i;
        return idx;
    endfunction

    function automatic logic [11:0] dut_hdr(input int c);
        return (c == 0) ? p_hdr_creds_reg : (c == 1) ? np_hdr_creds_reg : cpl_hdr_creds_reg;
    endfunction

    function automatic logic [15:0] dut_data(input int c);
        return (c == 0) ? p_data_creds_reg : (c == 1) ? np_data_creds_reg : cpl_data_creds_reg;
    endfunction

    vec_t        tbl [6];
    logic [7:0]  hold_h;
    logic [11:0] hold_d;
    logic [11:0] exp_first;
    int          idx;
    int          gap;
    int          guard;

    initial begin
        tbl[0] = '{2'd1, 4'd1, 9'd4, 1, 33, 516};
        tbl[1] = '{2'd0, 4'd3, 9'd10, 0, 35, 522};
        tbl[2] = '{2'd2, 4'd15, 9'd511, 2, 47, 1023};
        tbl[3] = '{2'd3, 4'd5, 9'd5, 0, 35, 522};
        tbl[4] = '{2'd1, 4'd0, 9'd0, 1, 33, 516};
        tbl[5] = '{2'd0, 4'd15, 9'd511, 0, 50, 1033};

        // Reset and the InitFC sequence.
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_valid", {31'd0, upd_valid}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        txq.delete();
        wait_txn(3, 20, "init_count");
        if (txq.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("init_is_init", {31'd0, txq[i].init}, 32'd1);
                chk("init_typ", {30'd0, txq[i].typ}, i);
                chk("init_hdr", {24'd0, txq[i].h}, 32'd32);
                chk("init_data", {20'd0, txq[i].d}, 32'd512);
            end
        end
        chk("init_done", {31'd0, init_done}, 32'd1);

        // Single NP release produces one UpdateFC.
        drain();
        txq.delete();
        rel(2'd1, 4'd1, 9'd4);
        chk("np_hdr_33", {20'd0, np_hdr_creds_reg}, 32'd33);
        chk("np_data_516", {16'd0, np_data_creds_reg}, 32'd516);
        wait_txn(1, 10, "np_upd_count");
        if (txq.size() >= 1) begin
            chk("np_upd_init", {31'd0, txq[0].init}, 32'd0);
            chk("np_upd_typ", {30'd0, txq[0].typ}, 32'd1);
            chk("np_upd_hdr", {24'd0, txq[0].h}, 32'd33);
            chk("np_upd_data", {20'd0, txq[0].d}, 32'd516);
        end

        // Round-robin: P granted, then NP, CPL, and the re-armed P last.
        drain();
        txq.delete();
        upd_ready = 1'b0;
        rel(2'd0, 4'd1, 9'd1);
        rel(2'd1, 4'd1, 9'd1);
        rel(2'd2, 4'd1, 9'd1);
        rel(2'd0, 4'd2, 9'd2);
        repeat (2) step();
        upd_ready = 1'b1;
        wait_txn(4, 20, "rr_count");
        if (txq.size() >= 4) begin
            chk("rr_typ0", {30'd0, txq[0].typ}, 32'd0);
            chk("rr_typ1", {30'd0, txq[1].typ}, 32'd1);
            chk("rr_typ2", {30'd0, txq[2].typ}, 32'd2);
            chk("rr_typ3", {30'd0, txq[3].typ}, 32'd0);
            chk("rr_first_p_hdr", {24'd0, txq[0].h}, {24'd0, 8'(m_hdr[0] - 12'd2)});
            chk("rr_last_p_hdr", {24'd0, txq[3].h}, {24'd0, m_hdr[0][7:0]});
            chk("rr_last_p_data", {20'd0, txq[3].d}, {20'd0, 12'(m_data[0])});
        end

        // Back-pressure for 5 cycles while newer NP releases arrive.
        drain();
        txq.delete();
        upd_ready = 1'b0;
        rel(2'd1, 4'd1, 9'd1);
        exp_first = m_hdr[1];
        for (int i = 0; i < 5 && !upd_valid; i++) step();
        chk("bp_valid", {31'd0, upd_valid}, 32'd1);
        hold_h = upd_hdr_creds;
        hold_d = upd_data_creds;
        chk("bp_first_hdr", {24'd0, hold_h}, {24'd0, exp_first[7:0]});
        for (int i = 0; i < 5; i++) begin
            rel(2'd1, 4'd2, 9'd3);
            chk("bp_stable_hdr", {24'd0, upd_hdr_creds}, {24'd0, hold_h});
            chk("bp_stable_data", {20'd0, upd_data_creds}, {20'd0, hold_d});
        end
        upd_ready = 1'b1;
        wait_txn(2, 12, "bp_count");
        if (txq.size() >= 2) begin
            chk("bp_txn0_hdr", {24'd0, txq[0].h}, {24'd0, hold_h});
            chk("bp_txn1_hdr", {24'd0, txq[1].h}, {24'd0, m_hdr[1][7:0]});
            chk("bp_txn1_data", {20'd0, txq[1].d}, {20'd0, 12'(m_data[1])});
        end

        // Data counter wrap with 16x data scale.
        drain();
        txq.delete();
        cfg_data_scale = 2'b11;
        guard = 0;
        while (m_data[0] != 16'hFFFF && guard < 300) begin
            gap = 65535 - int'(m_data[0]);
            rel(2'd0, 4'd0, 9'((gap > 511) ? 511 : gap));
            guard++;
        end
        chk("wrap_at_max", {16'd0, p_data_creds_reg}, 32'd65535);
        rel(2'd0, 4'd0, 9'd2);
        chk("wrap_to_1", {16'd0, p_data_creds_reg}, 32'd1);
        drain();
        idx = last_of(2'd0);
        chk("wrap_found", {31'd0, idx >= 0}, 32'd1);
        if (idx >= 0) begin
            chk("wrap_field", {20'd0, txq[idx].d}, 32'd0);
            chk("wrap_dscale", {30'd0, txq[idx].ds}, 32'd3);
        end

        // Header 16x, data 4x scaling on a CPL update.
        txq.delete();
        cfg_hdr_scale = 2'b11;
        cfg_data_scale = 2'b10;
        rel(2'd2, 4'd1, 9'd1);
        drain();
        idx = last_of(2'd2);
        chk("scale_found", {31'd0, idx >= 0}, 32'd1);
        if (idx >= 0) begin
            chk("scale_hdr", {24'd0, txq[idx].h}, {24'd0, 8'(m_hdr[2] >> 4)});
            chk("scale_data", {20'd0, txq[idx].d}, {20'd0, 12'(m_data[2] >> 2)});
            chk("scale_hs", {30'd0, txq[idx].hs}, 32'd3);
        end
        cfg_hdr_scale = 2'b00;
        cfg_data_scale = 2'b00;

        // Reset while a request is waiting.
        txq.delete();
        upd_ready = 1'b0;
        rel(2'd0, 4'd1, 9'd1);
        step();
        chk("mid_valid_before", {31'd0, upd_valid}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_valid_after", {31'd0, upd_valid}, 32'd0);
        chk("mid_init_done", {31'd0, init_done}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk("mid_hdr_init", {20'd0, dut_hdr(c)}, 32'd32);
            chk("mid_data_init", {16'd0, dut_data(c)}, 32'd512);
        end
        txq.delete();
        upd_ready = 1'b1;
        wait_txn(3, 20, "mid_reinit_count");
        if (txq.size() >= 1) begin
            chk("mid_reinit_flag", {31'd0, txq[0].init}, 32'd1);
            chk("mid_reinit_typ", {30'd0, txq[0].typ}, 32'd0);
        end

        // Vector table from the INIT counter values.
        step();
        for (int i = 0; i < 6; i++) begin
            rel(tbl[i].typ, tbl[i].h, tbl[i].d);
            chk("tbl_hdr", {20'd0, dut_hdr(tbl[i].cls)}, tbl[i].eh);
            chk("tbl_data", {16'd0, dut_data(tbl[i].cls)}, tbl[i].ed);
        end

        // Randomized traffic and back-pressure.
        drain();
        txq.delete();
        for (int i = 0; i < 400; i++) begin
            rel_valid = 1'($urandom_range(0, 1));
            rel_typ = 2'($urandom_range(0, 3));
            rel_hdr_creds = 4'($urandom);
            rel_data_creds = 9'($urandom);
            upd_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        upd_ready = 1'b1;
        rel(2'd0, 4'd1, 9'd1);
        rel(2'd1, 4'd1, 9'd1);
        rel(2'd2, 4'd1, 9'd1);
        drain();
        for (int c = 0; c < 3; c++) begin
            idx = last_of(2'(c));
            chk("rand_found", {31'd0, idx >= 0}, 32'd1);
            if (idx >= 0) begin
                chk("rand_last_hdr", {24'd0, txq[idx].h}, {24'd0, m_hdr[c][7:0]});
                chk("rand_last_data", {20'd0, txq[idx].d}, {20'd0, 12'(m_data[c])});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
